// File: rtl/dbus_wb_if_pkg.sv
// dbus_wb_if_pkg: shared state encodings and constants for the data-bus Wishbone bridge
package dbus_wb_if_pkg;
    typedef enum logic [1:0] {
        DBUS_IDLE       = 2'd0,
        DBUS_BUSY       = 2'd1,
        DBUS_WAIT_STALL = 2'd2
    } dbus_state_e;
    localparam int          DBUS_TIMEOUT = 255;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/dbus_wb_if.sv
// dbus_wb_if: turns the MEM stage's single-cycle RAM strobe into a Wishbone B4 classic cycle
module dbus_wb_if
    import dbus_wb_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = DBUS_TIMEOUT,
    parameter int STALL_BIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
    dbus_state_e state, state_nx;
    logic [7:0]  cnt;
    logic [31:0] rd_buf;
    logic        busy, hold, tmo, issue, done, ack_ok, abort;
    assign busy     = state == DBUS_BUSY;
    assign hold     = |(stall_i & (6'd1 << STALL_BIT));
    assign tmo      = cnt == CNT_LAST;
    assign issue    = state == DBUS_IDLE && cpu_ce_i && !flush_i;
    assign ack_ok   = busy && wb_ack_i && !flush_i;
    assign abort    = busy && !flush_i && !wb_ack_i && tmo;
    assign done     = busy && (flush_i || wb_ack_i || tmo);
    // cyc/stb follow the state directly so an async reset drops them immediately
    assign wb_cyc_o = busy;
    assign wb_stb_o = busy;
    // next-state: flush beats ack, ack beats timeout; a frozen MEM stage parks the result
    always_comb begin
        state_nx = state;
        case (state)
            DBUS_IDLE:       if (issue) state_nx = DBUS_BUSY;
            DBUS_BUSY:       if (flush_i) state_nx = DBUS_IDLE;
                             else if (wb_ack_i || tmo) state_nx = hold ? DBUS_WAIT_STALL : DBUS_IDLE;
            DBUS_WAIT_STALL: if (!hold || flush_i) state_nx = DBUS_IDLE;
            default:         state_nx = DBUS_IDLE;
        endcase
    end
    // state, latched bus request, read buffer, timeout counter and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DBUS_IDLE;
            wb_adr_o  <= ZERO_WORD;
            wb_dat_o  <= ZERO_WORD;
            wb_sel_o  <= 4'b0000;
            wb_we_o   <= 1'b0;
            rd_buf    <= ZERO_WORD;
            cnt       <= 8'd0;
            bus_err_o <= 1'b0;
        end else begin
            state     <= state_nx;
            bus_err_o <= abort;
            if (issue) begin
                wb_adr_o <= word_addr(cpu_addr_i);
                wb_dat_o <= cpu_data_i;
                wb_sel_o <= cpu_sel_i;
                wb_we_o  <= cpu_we_i;
                cnt      <= 8'd0;
            end else if (done) begin
                wb_we_o <= 1'b0;
                if (ack_ok && !wb_we_o) rd_buf <= wb_dat_i;
                if (abort) rd_buf <= ZERO_WORD;
            end else if (busy) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
    // stall request and load data back to MEM, both forced low while in reset
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        if (rst_n) begin
            stallreq_o = state == DBUS_IDLE ? cpu_ce_i && !flush_i : busy && !wb_ack_i && !tmo && !flush_i;
            cpu_data_o = ack_ok ? wb_dat_i : state == DBUS_WAIT_STALL ? rd_buf : ZERO_WORD;
        end
    end
endmodule

// File: tb/tb_dbus_wb_if.sv
// tb_dbus_wb_if: directed table, corner-case sequences and a randomized run against a transaction model
module tb_dbus_wb_if;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0, cpu_ce_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, wb_dat_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        stallreq_o, bus_err_o, wb_we_o, wb_cyc_o, wb_stb_o;
    int checks = 0, errors = 0;

    typedef struct {
        logic ce, we; logic [31:0] addr; logic [3:0] sel; logic [31:0] din;
        logic [5:0] stall; logic flush, ack; logic [31:0] rdat;
        logic e_req; logic [31:0] e_data; logic e_cyc, e_we;
        logic [31:0] e_adr, e_dat; logic [3:0] e_sel; logic e_err;
    } vec_t;
    vec_t tbl [14];

    bit          m_act, m_hold, m_we, m_weo, m_err, m_nerr, m_to;
    int          m_age;
    logic [31:0] m_adr, m_dat, m_buf, e_data;
    logic [3:0]  m_sel;
    logic        e_req;

    always #5 clk = ~clk;

    dbus_wb_if #(.TIMEOUT_CYC(T), .STALL_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // apply one cycle of inputs at the falling edge and settle before checks
    task automatic drive(input logic ce, input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [5:0] st, input logic fl,
                         input logic ack, input logic [31:0] rd);
        @(negedge clk);
        cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = a; cpu_sel_i = s; cpu_data_i = d;
        stall_i = st; flush_i = fl; wb_ack_i = ack; wb_dat_i = rd;
        #1;
    endtask

    initial begin
        // reset values, with a live request and ack on the inputs
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h700; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        #3;
        chk("rst_stallreq", 32'(stallreq_o), 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", 32'(wb_sel_o), 0);
        chk("rst_we", 32'(wb_we_o), 0);
        chk("rst_berr", 32'(bus_err_o), 0);
        cpu_ce_i = 1'b0; cpu_addr_i = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // LW with slow ack, SB, then flush colliding with ack
        tbl[0]  = '{1,0,32'h100,4'hF,0,6'h00,0,0,0,                 1,0,0,0,0,0,4'h0,0};
        tbl[1]  = '{1,0,32'h100,4'hF,0,6'h00,0,0,0,                 1,0,1,0,32'h100,0,4'hF,0};
        tbl[2]  = '{1,0,32'h100,4'hF,0,6'h0F,0,0,0,                 1,0,1,0,32'h100,0,4'hF,0};
        tbl[3]  = '{1,0,32'h100,4'hF,0,6'h00,0,0,0,                 1,0,1,0,32'h100,0,4'hF,0};
        tbl[4]  = '{1,0,32'h100,4'hF,0,6'h2F,0,1,32'hDEADBEEF,      0,32'hDEADBEEF,1,0,32'h100,0,4'hF,0};
        tbl[5]  = '{0,0,0,4'h0,0,6'h00,0,0,0,                       0,0,0,0,32'h100,0,4'hF,0};
        tbl[6]  = '{1,1,32'h103,4'h1,32'h5A5A5A5A,6'h00,0,0,0,      1,0,0,0,32'h100,0,4'hF,0};
        tbl[7]  = '{1,1,32'h103,4'h1,32'h5A5A5A5A,6'h00,0,1,32'h11111111, 0,32'h11111111,1,1,32'h100,32'h5A5A5A5A,4'h1,0};
        tbl[8]  = '{0,0,0,4'h0,0,6'h00,0,0,0,                       0,0,0,0,32'h100,32'h5A5A5A5A,4'h1,0};
        tbl[9]  = '{1,0,32'h200,4'hF,0,6'h00,0,0,0,                 1,0,0,0,32'h100,32'h5A5A5A5A,4'h1,0};
        tbl[10] = '{1,0,32'h200,4'hF,0,6'h00,0,0,0,                 1,0,1,0,32'h200,0,4'hF,0};
        tbl[11] = '{1,0,32'h200,4'hF,0,6'h00,1,1,32'hCAFEF00D,      0,0,1,0,32'h200,0,4'hF,0};
        tbl[12] = '{1,0,32'h200,4'hF,0,6'h00,1,0,0,                 0,0,0,0,32'h200,0,4'hF,0};
        tbl[13] = '{0,0,0,4'h0,0,6'h00,0,0,0,                       0,0,0,0,32'h200,0,4'hF,0};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].din,
                  tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].rdat);
            chk($sformatf("tbl%0d_stallreq", i), 32'(stallreq_o), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_cpu_data", i), cpu_data_o, tbl[i].e_data);
            chk($sformatf("tbl%0d_cyc", i), 32'(wb_cyc_o), 32'(tbl[i].e_cyc));
            chk($sformatf("tbl%0d_stb", i), 32'(wb_stb_o), 32'(tbl[i].e_cyc));
            chk($sformatf("tbl%0d_we", i), 32'(wb_we_o), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_adr", i), wb_adr_o, tbl[i].e_adr);
            chk($sformatf("tbl%0d_dat", i), wb_dat_o, tbl[i].e_dat);
            chk($sformatf("tbl%0d_sel", i), 32'(wb_sel_o), 32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_berr", i), 32'(bus_err_o), 32'(tbl[i].e_err));
        end

        // ack while a later stage stalls: value parked until the stall clears
        drive(1,0,32'h300,4'hF,0,6'h00,0,0,0);
        chk("ws_issue_req", 32'(stallreq_o), 1);
        drive(1,0,32'h300,4'hF,0,6'h00,0,0,0);
        chk("ws_busy_cyc", 32'(wb_cyc_o), 1);
        drive(1,0,32'h300,4'hF,0,6'b011111,0,1,32'h12345678);
        chk("ws_ack_data", cpu_data_o, 32'h12345678);
        chk("ws_ack_req", 32'(stallreq_o), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1,0,32'h300,4'hF,0,6'b011111,0,i == 1,32'hBAD0_0000 | i);
            chk("ws_hold_data", cpu_data_o, 32'h12345678);
            chk("ws_hold_req", 32'(stallreq_o), 0);
            chk("ws_hold_cyc", 32'(wb_cyc_o), 0);
        end
        drive(1,0,32'h300,4'hF,0,6'h00,0,0,0);
        chk("ws_release_data", cpu_data_o, 32'h12345678);
        chk("ws_release_cyc", 32'(wb_cyc_o), 0);
        drive(0,0,0,4'h0,0,6'h00,0,0,0);
        chk("ws_idle_data", cpu_data_o, 0);
        chk("ws_idle_cyc", 32'(wb_cyc_o), 0);

        // slave never answers: abort after T busy cycles
        drive(1,0,32'h400,4'hF,0,6'h00,0,0,0);
        chk("to_issue_req", 32'(stallreq_o), 1);
        for (int k = 1; k <= T; k++) begin
            drive(1,0,32'h400,4'hF,0,6'h00,0,0,32'h5555_5555);
            chk($sformatf("to_b%0d_req", k), 32'(stallreq_o), 32'(k < T));
            chk($sformatf("to_b%0d_cyc", k), 32'(wb_cyc_o), 1);
            chk($sformatf("to_b%0d_berr", k), 32'(bus_err_o), 0);
            chk($sformatf("to_b%0d_data", k), cpu_data_o, 0);
        end
        drive(0,0,0,4'h0,0,6'h00,0,0,0);
        chk("to_abort_cyc", 32'(wb_cyc_o), 0);
        chk("to_abort_berr", 32'(bus_err_o), 1);
        chk("to_abort_req", 32'(stallreq_o), 0);
        drive(0,0,0,4'h0,0,6'h00,0,0,0);
        chk("to_pulse_end", 32'(bus_err_o), 0);

        // async reset in the middle of a bus cycle, then a clean restart
        drive(1,0,32'h500,4'hF,0,6'h00,0,0,0);
        drive(1,0,32'h500,4'hF,0,6'h00,0,0,0);
        chk("ar_busy_cyc", 32'(wb_cyc_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cyc", 32'(wb_cyc_o), 0);
        chk("ar_stb", 32'(wb_stb_o), 0);
        chk("ar_req", 32'(stallreq_o), 0);
        cpu_ce_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1,0,32'h604,4'h3,0,6'h00,0,0,0);
        chk("ar_new_req", 32'(stallreq_o), 1);
        drive(1,0,32'h604,4'h3,0,6'h00,0,1,32'h0BADF00D);
        chk("ar_new_cyc", 32'(wb_cyc_o), 1);
        chk("ar_new_adr", wb_adr_o, 32'h604);
        chk("ar_new_data", cpu_data_o, 32'h0BADF00D);
        drive(0,0,0,4'h0,0,6'h00,0,0,0);
        chk("ar_new_done", 32'(wb_cyc_o), 0);

        // randomized traffic against a transaction-level model
        @(negedge clk);
        rst_n = 1'b0;
        cpu_ce_i = 1'b0; flush_i = 1'b0; wb_ack_i = 1'b0; stall_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_act = 0; m_hold = 0; m_we = 0; m_weo = 0; m_err = 0; m_age = 0;
        m_adr = '0; m_dat = '0; m_buf = '0; m_sel = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] st;
            st = 6'($urandom);
            st[4] = ($urandom % 3) == 0;
            drive($urandom % 2, $urandom % 2, $urandom, 4'($urandom), $urandom,
                  st, ($urandom % 20) == 0, ($urandom % 6) == 0, $urandom);
            m_to   = m_act && m_age == T - 1;
            e_req  = m_act ? (!wb_ack_i && !m_to && !flush_i) : m_hold ? 1'b0 : (cpu_ce_i && !flush_i);
            e_data = (m_act && wb_ack_i && !flush_i) ? wb_dat_i : m_hold ? m_buf : 32'h0;
            chk("rnd_stallreq", 32'(stallreq_o), 32'(e_req));
            chk("rnd_cpu_data", cpu_data_o, e_data);
            chk("rnd_cyc", 32'(wb_cyc_o), 32'(m_act));
            chk("rnd_stb", 32'(wb_stb_o), 32'(m_act));
            chk("rnd_we", 32'(wb_we_o), 32'(m_weo));
            chk("rnd_adr", wb_adr_o, m_adr);
            chk("rnd_dat", wb_dat_o, m_dat);
            chk("rnd_sel", 32'(wb_sel_o), 32'(m_sel));
            chk("rnd_berr", 32'(bus_err_o), 32'(m_err));
            m_nerr = 0;
            if (m_act) begin
                if (flush_i) begin
                    m_act = 0; m_weo = 0;
                end else if (wb_ack_i || m_to) begin
                    m_act = 0; m_weo = 0; m_hold = stall_i[4];
                    if (wb_ack_i) begin
                        if (!m_we) m_buf = wb_dat_i;
                    end else begin
                        m_buf = '0; m_nerr = 1;
                    end
                end else begin
                    m_age++;
                end
            end else if (m_hold) begin
                if (!stall_i[4] || flush_i) m_hold = 0;
            end else if (cpu_ce_i && !flush_i) begin
                m_act = 1; m_age = 0;
                m_adr = cpu_addr_i & 32'hFFFF_FFFC;
                m_dat = cpu_data_i; m_sel = cpu_sel_i; m_we = cpu_we_i; m_weo = cpu_we_i;
            end
            m_err = m_nerr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
